// File: rtl/btn_conditioner.sv
// Push-button conditioner: per-button two-flop synchroniser, counter debouncer,
// registered press pulse and sticky write-1-to-clear press flag.
module btn_conditioner #(
    parameter int unsigned N_BTN           = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 250000,
    parameter int unsigned CNT_W           = 18
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [N_BTN-1:0] BTN_RAW,
    output logic [N_BTN-1:0] BTN_LEVEL,
    output logic [N_BTN-1:0] BTN_PRESS,
    output logic [N_BTN-1:0] BTN_EVENT,
    input  logic [N_BTN-1:0] EVT_CLR,
    output logic             EVT_ANY
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [N_BTN-1:0]            s1_q, s1_d;
    logic [N_BTN-1:0]            s2_q, s2_d;
    logic [N_BTN-1:0]            level_q, level_d;
    logic [N_BTN-1:0]            press_q, press_d;
    logic [N_BTN-1:0]            event_q, event_d;
    logic [N_BTN-1:0][CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        s1_d    = BTN_RAW;
        s2_d    = s1_q;
        level_d = level_q;
        cnt_d   = cnt_q;
        // Count only while the synchronised value disagrees; any bounce restarts.
        for (int unsigned i = 0; i < N_BTN; i++) begin
            if (s2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                level_d[i] = s2_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
        press_d = level_d & ~level_q;
        // A press on the same edge as a clear wins.
        event_d = press_d | (event_q & ~EVT_CLR);
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_q    <= '0;
            s2_q    <= '0;
            level_q <= '0;
            press_q <= '0;
            event_q <= '0;
            cnt_q   <= '0;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            level_q <= level_d;
            press_q <= press_d;
            event_q <= event_d;
            cnt_q   <= cnt_d;
        end
    end

    assign BTN_LEVEL = level_q;
    assign BTN_PRESS = press_q;
    assign BTN_EVENT = event_q;
    assign EVT_ANY   = |event_q;

endmodule

// File: doc/btn_conditioner.md
Name: btn_conditioner

Overview:
- Conditions the four raw board push-buttons (BTND, BTNU, BTNR, BTNL) before they reach the nnRvSoc button input bus.
- Per button, it provides a two-flop synchroniser, a counter-based debouncer, a single-cycle press pulse and a sticky press-event flag.
- The sticky flag is cleared by the SoC through a write-1-to-clear strobe, so a firmware poll loop cannot miss a short press.
- It sits directly upstream of nnRvSoc. BTN_LEVEL is the vector that replaces the raw {BTND, BTNU, BTNR, BTNL} bundle.

Parameters:
- N_BTN, 4: number of independent buttons. Bit 3 = BTND, bit 2 = BTNU, bit 1 = BTNR, bit 0 = BTNL.
- DEBOUNCE_CYCLES, 250000: consecutive CLK cycles a synchronised value must hold before it is accepted. Legal range is 1 to 2^CNT_W-1. Simulation benches use 4.
- CNT_W, 18: debounce counter width per button.

Ports:
- CLK  in  1  system clock, the same clock as nnRvSoc.
- RST_N  in  1  asynchronous, active-low reset.
- BTN_RAW  in  N_BTN  raw, asynchronous, bouncing button pins; high = pressed.
- BTN_LEVEL  out  N_BTN  debounced button level; drives the nnRvSoc button bus.
- BTN_PRESS  out  N_BTN  one-cycle pulse on a debounced 0->1 transition.
- BTN_EVENT  out  N_BTN  sticky press flag per button.
- EVT_CLR  in  N_BTN  write-1-to-clear strobe for BTN_EVENT, one CLK wide, from SoC MMIO.
- EVT_ANY  out  1  OR-reduction of BTN_EVENT; usable as an interrupt or poll bit.

Behaviour:
- Reset: RST_N low clears all state immediately, with no CLK edge needed:
  - sync flops, stable levels, counters, BTN_LEVEL, BTN_PRESS, BTN_EVENT and EVT_ANY all go to 0.
  - Reset asserted mid-debounce discards the partial count.
  - On deassert, buttons are treated as released. A button held through reset produces a press once it has been debounced.
- Synchroniser: s1 <= BTN_RAW; s2 <= s1. Per-bit, no cross-bit coherency is guaranteed.
- Debounce, per bit, in the debounce state (counter cnt):
  - s2 == BTN_LEVEL: cnt <= 0.
  - s2 != BTN_LEVEL and cnt == DEBOUNCE_CYCLES-1: BTN_LEVEL <= s2; cnt <= 0.
  - otherwise: cnt <= cnt+1.
  - Any return of s2 to BTN_LEVEL before acceptance (a bounce) restarts the count from 0.
- Latency: if edge k is the first edge at which s1 captures the new raw value, and the value holds through edge k+1+DEBOUNCE_CYCLES, then BTN_LEVEL changes at edge k+1+DEBOUNCE_CYCLES.
- The counter saturates logically: it never exceeds DEBOUNCE_CYCLES-1, so there is no wrap.
- BTN_PRESS: registered. It is high for exactly the one cycle following the edge at which BTN_LEVEL goes 0->1. It is never asserted on a release.
- BTN_EVENT, per bit, evaluated at each edge:
  - press accepted at this edge: BTN_EVENT <= 1.
  - else EVT_CLR bit high: BTN_EVENT <= 0.
  - else: hold.
  - A press and a clear on the same edge leave the event set, so set wins and no press is lost.
  - Clearing an already-clear bit has no effect.
  - EVT_CLR held for several cycles clears repeatedly but cannot suppress a later press.
- EVT_ANY: combinational OR of the BTN_EVENT register bits. It is glitch-free because its only inputs are registers.
- Buttons are fully independent. Simultaneous presses on several bits each follow their own timing.
- Raw inputs are never used combinationally. Every output is registered, except EVT_ANY.

Test Plan:
1. Reset and basic press, DEBOUNCE_CYCLES=4:
   - Stimulus: hold RST_N=0 for 3 cycles with BTN_RAW=4'b0000. Check all outputs are 0. Release reset, then set BTN_RAW[2]=1 clean before edge k.
   - Required: BTN_LEVEL[2] rises at edge k+5; BTN_PRESS=4'b0100 for exactly 1 cycle; BTN_EVENT=4'b0100; EVT_ANY=1.
2. Bounce rejection:
   - Stimulus: toggle BTN_RAW[0] 1,0,1,0 with 2-cycle pulses, then hold 0.
   - Required: BTN_LEVEL[0], BTN_PRESS and BTN_EVENT stay 0 throughout.
   - Stimulus: bounce 3 times, then hold 1.
   - Required: BTN_LEVEL[0] rises exactly 5 cycles after the last s1 capture of 1.
3. Release and clear:
   - Stimulus: after scenario 1, drop BTN_RAW[2].
   - Required: BTN_LEVEL[2] falls 5 cycles later, with no BTN_PRESS and BTN_EVENT[2] still 1.
   - Stimulus: pulse EVT_CLR=4'b0100 for 1 cycle.
   - Required: BTN_EVENT=0 and EVT_ANY=0 on the next edge.
4. Set/clear collision:
   - Stimulus: align EVT_CLR[1]=1 with the edge at which BTN_LEVEL[1] rises.
   - Required: BTN_EVENT[1]=1 after that edge.
   - Stimulus: a further EVT_CLR[1] pulse.
   - Required: BTN_EVENT[1]=0.
5. Simultaneous buttons:
   - Stimulus: BTN_RAW=4'b1001 on the same cycle.
   - Required: BTN_PRESS=4'b1001 on one single cycle; BTN_EVENT=4'b1001.
   - Stimulus: EVT_CLR=4'b0001.
   - Required: BTN_EVENT=4'b1000; EVT_ANY=1.
6. Reset mid-debounce:
   - Stimulus: BTN_RAW[3]=1; assert RST_N=0 asynchronously 2 cycles later, mid-count, and release 1 cycle later while still holding BTN_RAW[3]=1.
   - Required: all outputs are 0 during reset; BTN_LEVEL[3] rises exactly 5 cycles after the first post-reset s1 capture, with one BTN_PRESS pulse.
